// File: rtl/loop_cntr_ctl_pkg.sv
// Shared definitions for the loop-counter controller: default widths, reset count and FSM encoding.
// Optional build macro: CNT_ZERO_FULL_EN (a loaded 0 means 2^CW iterations).
package loop_cntr_ctl_pkg;

    localparam int CW_DEF      = 14;
    localparam int RST_CNT_DEF = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_LAST = 2'b10
    } cntr_state_e;

endpackage

// File: rtl/loop_cntr_ctl_cntr_dec.sv
// Combinational CNTR decrement with wrap/hold select, plus last-iteration compare on a candidate next value.
// Optional build macro: CNT_ZERO_FULL_EN selects 0 = 2^CW iterations instead of 0 treated as 1.
module loop_cntr_ctl_cntr_dec #(
    parameter int CW = 14
) (
    input  logic [CW-1:0] cur_i,
    input  logic [CW-1:0] nxt_i,
    output logic [CW-1:0] dec_o,
    output logic          nxt_last_o
);

    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

`ifdef CNT_ZERO_FULL_EN
    // Only 1 terminates; 0 wraps to all-ones so it runs the full 2^CW iterations.
    always_comb begin
        dec_o      = cur_i;
        nxt_last_o = 1'b0;
        if (cur_i == CNT_ONE) begin
            dec_o = cur_i;
        end else begin
            dec_o = cur_i - CNT_ONE;
        end
        nxt_last_o = (nxt_i == CNT_ONE);
    end
`else
    // 0 behaves as 1: both are terminal and both hold on a further decrement.
    always_comb begin
        dec_o      = cur_i;
        nxt_last_o = 1'b0;
        if ((cur_i == CNT_ONE) || (cur_i == CNT_ZERO)) begin
            dec_o = cur_i;
        end else begin
            dec_o = cur_i - CNT_ONE;
        end
        nxt_last_o = (nxt_i == CNT_ONE) || (nxt_i == CNT_ZERO);
    end
`endif

endmodule

// File: rtl/loop_cntr_ctl.sv
// Active loop-counter register (CNTR) with count-stack push/pop handshake, CE decode and sticky flags.
// Optional build macro: CNT_ZERO_FULL_EN (see loop_cntr_ctl_cntr_dec).
module loop_cntr_ctl
    import loop_cntr_ctl_pkg::*;
#(
    parameter int CW      = CW_DEF,
    parameter int RST_CNT = RST_CNT_DEF
) (
    input  logic          DSPCLK,
    input  logic          T_RST,
    input  logic          cntr_we,
    input  logic [CW-1:0] cntr_din,
    input  logic          cnt_dec,
    input  logic          loop_pop,
    input  logic          flag_clr,
    input  logic          CNT_full,
    input  logic          CNT_empty,
    input  logic [CW-1:0] TopCNT,
    output logic [CW-1:0] CNTin,
    output logic          PushCNT_EN,
    output logic          PopCNT_EN,
    output logic          CNS_CKenb,
    output logic [CW-1:0] cntr_q,
    output logic          cnt_vld,
    output logic          CE,
    output logic          cnt_ovf,
    output logic          cnt_unf
);

    localparam logic [CW-1:0] RST_VAL = CW'(RST_CNT);

    cntr_state_e   state_q, state_d;
    logic [CW-1:0] cntr_d;
    logic          vld_q, vld_d;
    logic          ce_q, ce_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          push_s, pop_s;
    logic          ovf_set_s, unf_set_s;
    logic [CW-1:0] dec_s;
    logic          nxt_last_s;

    loop_cntr_ctl_cntr_dec #(
        .CW (CW)
    ) u_cntr_dec (
        .cur_i      (cntr_q),
        .nxt_i      (cntr_d),
        .dec_o      (dec_s),
        .nxt_last_o (nxt_last_s)
    );

    // Next-state: priority reset > write > pop > decrement; stack requests are combinational.
    always_comb begin
        push_s    = 1'b0;
        pop_s     = 1'b0;
        cntr_d    = cntr_q;
        vld_d     = vld_q;
        ovf_set_s = 1'b0;
        unf_set_s = 1'b0;
        if (T_RST) begin
            cntr_d = RST_VAL;
            vld_d  = 1'b0;
        end else if (cntr_we) begin
            cntr_d = cntr_din;
            vld_d  = 1'b1;
            // A write with a same-cycle pop nets out to no stack traffic.
            if (vld_q && !loop_pop) begin
                if (CNT_full) begin
                    ovf_set_s = 1'b1;
                end else begin
                    push_s = 1'b1;
                end
            end else begin
                push_s = 1'b0;
            end
        end else if (loop_pop) begin
            if (!CNT_empty) begin
                pop_s  = 1'b1;
                cntr_d = TopCNT;
                vld_d  = 1'b1;
            end else begin
                vld_d     = 1'b0;
                unf_set_s = !vld_q;
            end
        end else if (cnt_dec && vld_q) begin
            cntr_d = dec_s;
        end else begin
            cntr_d = cntr_q;
        end
    end

    // FSM state, registered CE and sticky flags derived from the next CNTR contents.
    always_comb begin
        state_d = state_q;
        if (!vld_d) begin
            state_d = ST_IDLE;
        end else if (nxt_last_s) begin
            state_d = ST_LAST;
        end else begin
            state_d = ST_RUN;
        end
        ce_d = (state_d == ST_LAST);
        if (T_RST) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            ovf_d = ovf_set_s | (ovf_q & ~flag_clr);
            unf_d = unf_set_s | (unf_q & ~flag_clr);
        end
    end

    // Register file for CNTR, FSM and flags; reset is synchronous.
    always_ff @(posedge DSPCLK) begin
        if (T_RST) begin
            state_q <= ST_IDLE;
            cntr_q  <= RST_VAL;
            vld_q   <= 1'b0;
            ce_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cntr_q  <= cntr_d;
            vld_q   <= vld_d;
            ce_q    <= ce_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign CNTin      = cntr_q;
    assign PushCNT_EN = push_s;
    assign PopCNT_EN  = pop_s;
    assign CNS_CKenb  = !(push_s || pop_s);
    assign cnt_vld    = vld_q;
    assign CE         = ce_q;
    assign cnt_ovf    = ovf_q;
    assign cnt_unf    = unf_q;

endmodule

// File: tb/tb_loop_cntr_ctl.sv
// Self-checking bench for loop_cntr_ctl: directed scenarios plus randomized traffic against a
// behavioural model that also plays the 4-deep count stack.
module tb_loop_cntr_ctl;

`ifdef CNT_ZERO_FULL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        DSPCLK = 1'b0;
    logic        T_RST = 1'b0, cntr_we = 1'b0, cnt_dec = 1'b0, loop_pop = 1'b0, flag_clr = 1'b0;
    logic [13:0] cntr_din = 14'd0;
    logic        CNT_full = 1'b0, CNT_empty = 1'b1;
    logic [13:0] TopCNT = 14'd0;
    logic [13:0] CNTin, cntr_q;
    logic        PushCNT_EN, PopCNT_EN, CNS_CKenb, cnt_vld, CE, cnt_ovf, cnt_unf;

    int total = 0;
    int bad   = 0;

    // Model state and the environment stack
    logic [13:0] m_cnt = 14'd0;
    logic        m_vld = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
    logic [13:0] stk[$];
    logic        exp_push, exp_pop;
    logic [13:0] exp_cntin;
    logic        obs_push, obs_pop, obs_ckenb;
    logic [13:0] obs_cntin;

    always #5 DSPCLK = ~DSPCLK;

    loop_cntr_ctl dut (
        .DSPCLK(DSPCLK), .T_RST(T_RST), .cntr_we(cntr_we), .cntr_din(cntr_din),
        .cnt_dec(cnt_dec), .loop_pop(loop_pop), .flag_clr(flag_clr),
        .CNT_full(CNT_full), .CNT_empty(CNT_empty), .TopCNT(TopCNT),
        .CNTin(CNTin), .PushCNT_EN(PushCNT_EN), .PopCNT_EN(PopCNT_EN),
        .CNS_CKenb(CNS_CKenb), .cntr_q(cntr_q), .cnt_vld(cnt_vld), .CE(CE),
        .cnt_ovf(cnt_ovf), .cnt_unf(cnt_unf)
    );

    function automatic logic [13:0] ref_dec(input logic [13:0] c);
        int n;
        n = int'(c);
        if (n == 1 || (!ZF && n == 0)) return c;
        return 14'((n + 16383) % 16384);
    endfunction

    function automatic logic ref_ce();
        return m_vld && (m_cnt == 14'd1 || (!ZF && m_cnt == 14'd0));
    endfunction

    // One clock of stimulus: drives inputs, records combinational outputs, advances model and stack.
    task automatic cycle(input logic rst, input logic we, input logic [13:0] din,
                         input logic dec, input logic pop, input logic clr);
        logic ovf_set, unf_set;
        T_RST = rst; cntr_we = we; cntr_din = din; cnt_dec = dec; loop_pop = pop; flag_clr = clr;
        CNT_full  = (stk.size() == 4);
        CNT_empty = (stk.size() == 0);
        TopCNT    = CNT_empty ? 14'd0 : stk[stk.size()-1];
        exp_push  = !rst && we && m_vld && !pop && !CNT_full;
        exp_pop   = !rst && !we && pop && !CNT_empty;
        exp_cntin = m_cnt;
        #2;
        obs_push = PushCNT_EN; obs_pop = PopCNT_EN; obs_ckenb = CNS_CKenb; obs_cntin = CNTin;
        ovf_set = 1'b0; unf_set = 1'b0;
        if (rst) begin
            m_cnt = 14'd0; m_vld = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
            stk.delete();
        end else begin
            if (we) begin
                ovf_set = m_vld && !pop && CNT_full;
                if (exp_push) stk.push_back(m_cnt);
                m_cnt = din; m_vld = 1'b1;
            end else if (pop) begin
                if (!CNT_empty) begin
                    m_cnt = stk.pop_back(); m_vld = 1'b1;
                end else begin
                    unf_set = !m_vld; m_vld = 1'b0;
                end
            end else if (dec && m_vld) begin
                m_cnt = ref_dec(m_cnt);
            end
            m_ovf = ovf_set || (m_ovf && !clr);
            m_unf = unf_set || (m_unf && !clr);
        end
        @(posedge DSPCLK);
        #1;
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        total++; if (cntr_q !== 14'd0 || cnt_vld !== 1'b0 || CE !== 1'b0) begin bad++;
            $display("FAIL reset_state: cntr=%0d vld=%b ce=%b, want 0/0/0", cntr_q, cnt_vld, CE); end
        total++; if (cnt_ovf !== 1'b0 || cnt_unf !== 1'b0) begin bad++;
            $display("FAIL reset_flags: ovf=%b unf=%b, want 0/0", cnt_ovf, cnt_unf); end
        cycle(1'b0, 1'b1, 14'd5, 1'b0, 1'b0, 1'b0);
        total++; if (cntr_q !== 14'd5 || cnt_vld !== 1'b1) begin bad++;
            $display("FAIL reset_load5: cntr=%0d vld=%b, want 5/1", cntr_q, cnt_vld); end
        cycle(1'b1, 1'b1, 14'd9, 1'b1, 1'b0, 1'b0);
        total++; if (obs_push !== 1'b0 || obs_ckenb !== 1'b1) begin bad++;
            $display("FAIL reset_gate: push=%b ckenb=%b, want 0/1", obs_push, obs_ckenb); end
        total++; if (cntr_q !== 14'd0 || cnt_vld !== 1'b0 || CE !== 1'b0) begin bad++;
            $display("FAIL reset_midrun: cntr=%0d vld=%b ce=%b, want 0/0/0", cntr_q, cnt_vld, CE); end
    endtask

    task automatic test_decrement();
        logic [13:0] want [4] = '{14'd3, 14'd2, 14'd1, 14'd1};
        logic        wce  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd3, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++; if (cntr_q !== want[i] || CE !== wce[i]) begin bad++;
                $display("FAIL dec_step%0d: cntr=%0d ce=%b, want %0d/%b", i, cntr_q, CE, want[i], wce[i]); end
            if (i < 3) cycle(1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_nest();
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd10, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd7, 1'b0, 1'b0, 1'b0);
        total++; if (obs_push !== 1'b1 || obs_cntin !== 14'd10 || obs_ckenb !== 1'b0 || cntr_q !== 14'd7) begin bad++;
            $display("FAIL nest_push: push=%b cntin=%0d ckenb=%b cntr=%0d, want 1/10/0/7", obs_push, obs_cntin, obs_ckenb, cntr_q); end
        cycle(1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || cntr_q !== 14'd10 || cnt_vld !== 1'b1) begin bad++;
            $display("FAIL nest_pop: pop=%b cntr=%0d vld=%b, want 1/10/1", obs_pop, cntr_q, cnt_vld); end
        cycle(1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b0 || cnt_vld !== 1'b0 || cntr_q !== 14'd10 || cnt_unf !== 1'b0) begin bad++;
            $display("FAIL nest_empty: pop=%b vld=%b cntr=%0d unf=%b, want 0/0/10/0", obs_pop, cnt_vld, cntr_q, cnt_unf); end
        cycle(1'b0, 1'b0, 14'd0, 1'b0, 1'b1, 1'b0);
        total++; if (cnt_unf !== 1'b1) begin bad++;
            $display("FAIL nest_unf: unf=%b, want 1", cnt_unf); end
    endtask

    task automatic test_overflow();
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 5; i++) cycle(1'b0, 1'b1, 14'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd9, 1'b0, 1'b0, 1'b0);
        total++; if (obs_push !== 1'b0 || cnt_ovf !== 1'b1 || cntr_q !== 14'd9) begin bad++;
            $display("FAIL ovf_set: push=%b ovf=%b cntr=%0d, want 0/1/9", obs_push, cnt_ovf, cntr_q); end
        cycle(1'b0, 1'b0, 14'd0, 1'b0, 1'b0, 1'b1);
        total++; if (cnt_ovf !== 1'b0) begin bad++;
            $display("FAIL ovf_clr: ovf=%b, want 0", cnt_ovf); end
        cycle(1'b0, 1'b1, 14'd11, 1'b0, 1'b0, 1'b1);
        total++; if (cnt_ovf !== 1'b1 || cntr_q !== 14'd11) begin bad++;
            $display("FAIL ovf_setwins: ovf=%b cntr=%0d, want 1/11", cnt_ovf, cntr_q); end
    endtask

    task automatic test_same_cycle();
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd8, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd6, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd4, 1'b0, 1'b1, 1'b0);
        total++; if (obs_push !== 1'b0 || obs_pop !== 1'b0 || obs_ckenb !== 1'b1 || cntr_q !== 14'd4) begin bad++;
            $display("FAIL we_pop: push=%b pop=%b ckenb=%b cntr=%0d, want 0/0/1/4", obs_push, obs_pop, obs_ckenb, cntr_q); end
        cycle(1'b0, 1'b0, 14'd0, 1'b1, 1'b1, 1'b0);
        total++; if (obs_pop !== 1'b1 || cntr_q !== 14'd8) begin bad++;
            $display("FAIL dec_pop: pop=%b cntr=%0d, want 1/8", obs_pop, cntr_q); end
    endtask

    task automatic test_zero_load();
        logic        want_ce0;
        logic [13:0] want_dec;
        want_ce0 = !ZF;
        want_dec = ZF ? 14'd16383 : 14'd0;
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 14'd0, 1'b0, 1'b0, 1'b0);
        total++; if (cntr_q !== 14'd0 || CE !== want_ce0) begin bad++;
            $display("FAIL zero_load: cntr=%0d ce=%b, want 0/%b", cntr_q, CE, want_ce0); end
        cycle(1'b0, 1'b0, 14'd0, 1'b1, 1'b0, 1'b0);
        total++; if (cntr_q !== want_dec || CE !== want_ce0) begin bad++;
            $display("FAIL zero_dec: cntr=%0d ce=%b, want %0d/%b", cntr_q, CE, want_dec, want_ce0); end
    endtask

    task automatic test_random();
        logic rst, we, dec, pop, clr;
        logic [13:0] din;
        cycle(1'b1, 1'b0, 14'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) < 2);
            we  = ($urandom_range(0, 99) < 25);
            pop = ($urandom_range(0, 99) < 20);
            dec = ($urandom_range(0, 99) < 50);
            clr = ($urandom_range(0, 99) < 8);
            din = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 4)) : 14'($urandom);
            cycle(rst, we, din, dec, pop, clr);
            total++; if (obs_push !== exp_push || obs_pop !== exp_pop || obs_ckenb !== !(exp_push || exp_pop)) begin bad++;
                $display("FAIL rnd_stack[%0d]: push=%b pop=%b ckenb=%b, want %b/%b/%b", n, obs_push, obs_pop, obs_ckenb,
                         exp_push, exp_pop, !(exp_push || exp_pop)); end
            total++; if (obs_cntin !== exp_cntin) begin bad++;
                $display("FAIL rnd_cntin[%0d]: cntin=%0d, want %0d", n, obs_cntin, exp_cntin); end
            total++; if (cntr_q !== m_cnt || cnt_vld !== m_vld || CE !== ref_ce()) begin bad++;
                $display("FAIL rnd_cntr[%0d]: cntr=%0d vld=%b ce=%b, want %0d/%b/%b", n, cntr_q, cnt_vld, CE, m_cnt, m_vld, ref_ce()); end
            total++; if (cnt_ovf !== m_ovf || cnt_unf !== m_unf) begin bad++;
                $display("FAIL rnd_flags[%0d]: ovf=%b unf=%b, want %b/%b", n, cnt_ovf, cnt_unf, m_ovf, m_unf); end
        end
    endtask

    initial begin
        test_reset();
        test_decrement();
        test_nest();
        test_overflow();
        test_same_cycle();
        test_zero_load();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
